// File: rtl/soc_gpio_ctrl.sv
// Memory-mapped GPIO controller: output register with set/clear aliases, input
// synchroniser, per-pin rising/falling edge status (W1C) and one level interrupt.
module soc_gpio_ctrl #(
    parameter logic [31:0] DOUT_RST_VALUE = 32'h0000_0000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    output logic        gnt,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic [31:0] gpio_dout,
    input  logic [31:0] gpio_din,
    output logic        gpio_irq
);

    localparam logic [2:0] REG_ODR  = 3'd0;
    localparam logic [2:0] REG_IDR  = 3'd1;
    localparam logic [2:0] REG_RIER = 3'd2;
    localparam logic [2:0] REG_FIER = 3'd3;
    localparam logic [2:0] REG_RISR = 3'd4;
    localparam logic [2:0] REG_FISR = 3'd5;
    localparam logic [2:0] REG_OSET = 3'd6;
    localparam logic [2:0] REG_OCLR = 3'd7;

    logic [SYNC_STAGES-1:0][31:0] sync_r;
    logic [31:0] prev_r;
    logic [31:0] odr_r;
    logic [31:0] rier_r;
    logic [31:0] fier_r;
    logic [31:0] risr_r;
    logic [31:0] fisr_r;
    logic        rvalid_r;
    logic [31:0] rdata_r;
    logic        irq_r;

    logic        wr_s;
    logic [2:0]  sel_s;
    logic [31:0] s_last_s;
    logic [31:0] rise_s;
    logic [31:0] fall_s;
    logic [31:0] rclr_s;
    logic [31:0] fclr_s;
    logic [31:0] odr_nxt_s;
    logic [31:0] rier_nxt_s;
    logic [31:0] fier_nxt_s;
    logic [31:0] rd_mux_s;
    logic        irq_nxt_s;
    logic        addr_unused_s;

    // Byte-lane bits carry no meaning on a word-only register file.
    assign addr_unused_s = ^addr[1:0];

    assign gnt       = req;
    assign rvalid    = rvalid_r;
    assign rdata     = rdata_r;
    assign gpio_dout = odr_r;
    assign gpio_irq  = irq_r;

    assign wr_s     = req & we;
    assign sel_s    = addr[4:2];
    assign s_last_s = sync_r[SYNC_STAGES-1];
    assign rise_s   = s_last_s & ~prev_r;
    assign fall_s   = ~s_last_s & prev_r;

    // Address decode: read mux and next-state of every writable register.
    always_comb begin
        rd_mux_s   = 32'h0000_0000;
        odr_nxt_s  = odr_r;
        rier_nxt_s = rier_r;
        fier_nxt_s = fier_r;
        rclr_s     = 32'h0000_0000;
        fclr_s     = 32'h0000_0000;
        case (sel_s)
            REG_ODR: begin
                rd_mux_s = odr_r;
                if (wr_s) odr_nxt_s = wdata;
                else      odr_nxt_s = odr_r;
            end
            REG_IDR: begin
                rd_mux_s = s_last_s;
            end
            REG_RIER: begin
                rd_mux_s = rier_r;
                if (wr_s) rier_nxt_s = wdata;
                else      rier_nxt_s = rier_r;
            end
            REG_FIER: begin
                rd_mux_s = fier_r;
                if (wr_s) fier_nxt_s = wdata;
                else      fier_nxt_s = fier_r;
            end
            REG_RISR: begin
                rd_mux_s = risr_r;
                if (wr_s) rclr_s = wdata;
                else      rclr_s = 32'h0000_0000;
            end
            REG_FISR: begin
                rd_mux_s = fisr_r;
                if (wr_s) fclr_s = wdata;
                else      fclr_s = 32'h0000_0000;
            end
            REG_OSET: begin
                rd_mux_s = 32'h0000_0000;
                if (wr_s) odr_nxt_s = odr_r | wdata;
                else      odr_nxt_s = odr_r;
            end
            REG_OCLR: begin
                rd_mux_s = 32'h0000_0000;
                if (wr_s) odr_nxt_s = odr_r & ~wdata;
                else      odr_nxt_s = odr_r;
            end
            default: begin
                rd_mux_s = 32'h0000_0000;
            end
        endcase
    end

    // Interrupt request before its output register.
    always_comb begin
        irq_nxt_s = |((risr_r & rier_r) | (fisr_r & fier_r));
    end

    // Input synchroniser chain plus the one-cycle delay used for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= '0;
            prev_r <= 32'h0000_0000;
        end else begin
            sync_r[0] <= gpio_din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r <= s_last_s;
        end
    end

    // Control and status registers; a fresh edge beats a simultaneous W1C.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            odr_r  <= DOUT_RST_VALUE;
            rier_r <= 32'h0000_0000;
            fier_r <= 32'h0000_0000;
            risr_r <= 32'h0000_0000;
            fisr_r <= 32'h0000_0000;
        end else begin
            odr_r  <= odr_nxt_s;
            rier_r <= rier_nxt_s;
            fier_r <= fier_nxt_s;
            risr_r <= (risr_r & ~rclr_s) | rise_s;
            fisr_r <= (fisr_r & ~fclr_s) | fall_s;
        end
    end

    // Bus response and interrupt output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0000_0000;
            irq_r    <= 1'b0;
        end else begin
            rvalid_r <= req;
            rdata_r  <= req ? rd_mux_s : 32'h0000_0000;
            irq_r    <= irq_nxt_s;
        end
    end

endmodule

// File: tb/tb_soc_gpio_ctrl.sv
// Directed self-checking bench for soc_gpio_ctrl (SYNC_STAGES=2).
module tb_soc_gpio_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        gnt;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] gpio_dout;
    logic [31:0] gpio_din;
    logic        gpio_irq;

    int n_checks_r = 0;
    int n_fail_r   = 0;

    soc_gpio_ctrl #(
        .DOUT_RST_VALUE(32'hA5A5_0000),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .gnt(gnt),
        .we(we),
        .addr(addr),
        .wdata(wdata),
        .rvalid(rvalid),
        .rdata(rdata),
        .gpio_dout(gpio_dout),
        .gpio_din(gpio_din),
        .gpio_irq(gpio_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks_r++;
        if (obs !== exp) begin
            n_fail_r++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One granted access; outputs are sampled just after the granting edge.
    task automatic bus(input logic w, input logic [7:0] off, input logic [31:0] d,
                       output logic [31:0] rd, output logic v);
        req   = 1'b1;
        we    = w;
        addr  = off[4:0];
        wdata = d;
        #1;
        chk("gnt", {31'h0, gnt}, 32'h1);
        @(posedge clk);
        #1;
        rd    = rdata;
        v     = rvalid;
        req   = 1'b0;
        we    = 1'b0;
        wdata = 32'h0000_0000;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] rd;
        logic        v;
        bus(1'b1, off, d, rd, v);
        chk("wr_rvalid", {31'h0, v}, 32'h1);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        logic        v;
        bus(1'b0, off, 32'h0000_0000, rd, v);
        chk({tag, "_rvalid"}, {31'h0, v}, 32'h1);
        chk(tag, rd, exp);
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 1'b0;
        we       = 1'b0;
        addr     = 5'h00;
        wdata    = 32'h0000_0000;
        gpio_din = 32'h0000_0000;

        // 1: reset values
        tick(); tick(); tick();
        chk("rst_dout", gpio_dout, 32'hA5A5_0000);
        chk("rst_irq", {31'h0, gpio_irq}, 32'h0);
        chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        rd_chk("risr_rst", 8'h10, 32'h0);

        // 2: output register, set/clear aliases, write-only and unmapped reads
        wr(8'h00, 32'h0000_00F0);
        chk("dout_odr", gpio_dout, 32'h0000_00F0);
        wr(8'h18, 32'h0000_0001);
        chk("dout_oset", gpio_dout, 32'h0000_00F1);
        wr(8'h1C, 32'h0000_0010);
        chk("dout_oclr", gpio_dout, 32'h0000_00E1);
        rd_chk("odr_rd", 8'h00, 32'h0000_00E1);
        rd_chk("oset_rd", 8'h18, 32'h0);
        rd_chk("off3c_rd", 8'h3C, 32'h0);
        wr(8'h04, 32'hFFFF_FFFF);
        rd_chk("idr_wr_ignored", 8'h04, 32'h0);
        tick();
        chk("idle_rvalid", {31'h0, rvalid}, 32'h0);
        chk("idle_rdata", rdata, 32'h0);

        // 3: rising edge on pin 0 -> IDR at N+1, RISR at N+2, irq after N+3
        wr(8'h08, 32'h0000_0001);
        gpio_din = 32'h0000_0001;
        tick();                                  // edge N
        rd_chk("idr_n1", 8'h04, 32'h0);          // granted at N+1, pre-update
        rd_chk("idr_n2", 8'h04, 32'h1);          // granted at N+2
        chk("irq_n2", {31'h0, gpio_irq}, 32'h0);
        rd_chk("risr_n3", 8'h10, 32'h1);         // granted at N+3
        chk("irq_n3", {31'h0, gpio_irq}, 32'h1);
        wr(8'h10, 32'h0000_0001);
        chk("irq_clr_g", {31'h0, gpio_irq}, 32'h1);
        tick();
        chk("irq_clr_g1", {31'h0, gpio_irq}, 32'h0);
        rd_chk("risr_cleared", 8'h10, 32'h0);

        // 4: falling edge on pin 5 with its enable off, then enable it
        gpio_din = 32'h0000_0021;
        repeat (4) tick();
        gpio_din = 32'h0000_0001;
        repeat (4) tick();
        rd_chk("fisr_b5", 8'h14, 32'h0000_0020);
        chk("irq_fier_off", {31'h0, gpio_irq}, 32'h0);
        rd_chk("risr_b5", 8'h10, 32'h0000_0020);
        wr(8'h0C, 32'h0000_0020);
        chk("irq_fier_g", {31'h0, gpio_irq}, 32'h0);
        tick();
        chk("irq_fier_g1", {31'h0, gpio_irq}, 32'h1);

        // 5: W1C on RISR[3] in the same cycle as a new rise on pin 3
        wr(8'h0C, 32'h0);
        wr(8'h08, 32'h0000_0008);
        gpio_din = 32'h0000_0009;
        repeat (4) tick();
        chk("irq_b3", {31'h0, gpio_irq}, 32'h1);
        gpio_din = 32'h0000_0001;
        repeat (4) tick();
        gpio_din = 32'h0000_0009;
        tick();                                  // edge M
        tick();                                  // edge M+1
        wr(8'h10, 32'h0000_0008);                // granted at M+2 with rise active
        chk("irq_race_g", {31'h0, gpio_irq}, 32'h1);
        tick();
        chk("irq_race_g1", {31'h0, gpio_irq}, 32'h1);
        rd_chk("risr_race", 8'h10, 32'h0000_0028);
        wr(8'h10, 32'h0000_0008);
        tick();
        chk("irq_b3_clr", {31'h0, gpio_irq}, 32'h0);
        rd_chk("risr_b3_clr", 8'h10, 32'h0000_0020);

        // 6: reset during a granted read drops the response
        req   = 1'b1;
        we    = 1'b0;
        addr  = 5'h04;
        rst_n = 1'b0;
        tick();
        req   = 1'b0;
        chk("rstmid_rvalid", {31'h0, rvalid}, 32'h0);
        chk("rstmid_rdata", rdata, 32'h0);
        chk("rstmid_dout", gpio_dout, 32'hA5A5_0000);
        chk("rstmid_irq", {31'h0, gpio_irq}, 32'h0);
        rst_n = 1'b1;
        rd_chk("rstmid_risr", 8'h10, 32'h0);
        rd_chk("rstmid_fisr", 8'h14, 32'h0);
        rd_chk("rstmid_rier", 8'h08, 32'h0);
        rd_chk("rstmid_fier", 8'h0C, 32'h0);
        rd_chk("rstmid_odr", 8'h00, 32'hA5A5_0000);
        rd_chk("idr_after_rst", 8'h04, 32'h0000_0009);
        wr(8'h00, 32'h1234_5678);
        wr(8'h08, 32'hCAFE_0000);
        wr(8'h0C, 32'h0000_BEEF);
        rd_chk("b2b_odr", 8'h00, 32'h1234_5678);
        rd_chk("b2b_rier", 8'h08, 32'hCAFE_0000);
        rd_chk("b2b_fier", 8'h0C, 32'h0000_BEEF);
        tick();
        chk("b2b_end_rvalid", {31'h0, rvalid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks_r, n_fail_r);
        $finish;
    end

endmodule
